// File: rtl/spi_clk_cfg_sequencer.sv
// Jitter-cleaner SPI sequencer: shares one SPI engine between a boot-time
// configuration table (external ROM) and single-word software requests,
// then pulses SYNC once the boot table has been written.
module spi_clk_cfg_sequencer #(
  parameter int N_BOOT_WORDS      = 8,
  parameter int TIMEOUT_CYCLES    = 4095,
  parameter int SYNC_PULSE_CYCLES = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        boot_start_i,
  output logic [7:0]  boot_addr_o,
  input  logic [31:0] boot_word_i,
  input  logic [1:0]  boot_sel_i,
  input  logic        sw_req_i,
  input  logic [1:0]  sw_sel_i,
  input  logic [31:0] sw_data_i,
  output logic        sw_ack_o,
  output logic [31:0] sw_rdata_o,
  output logic        sw_timeout_o,
  output logic        spi_go_o,
  output logic [31:0] spi_in_o,
  output logic [1:0]  spi_slave_select_o,
  input  logic [31:0] spi_out_i,
  input  logic        spi_done_i,
  output logic        sync_o,
  output logic        busy_o,
  output logic        boot_done_o,
  output logic [7:0]  err_count_o
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_BOOT_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE      = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
  localparam logic [2:0] ST_SW_RESP    = 3'd4;
  localparam logic [2:0] ST_SYNC_PULSE = 3'd5;

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SYN_W = (SYNC_PULSE_CYCLES > 1) ? $clog2(SYNC_PULSE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SYN_W-1:0] SYN_LAST  = SYN_W'(SYNC_PULSE_CYCLES - 1);
  localparam logic [7:0]       LAST_ADDR = 8'(N_BOOT_WORDS - 1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       boot_addr_q, boot_addr_d;
  logic [31:0]      word_q, word_d;
  logic [1:0]       sel_q, sel_d;
  logic             src_sw_q, src_sw_d;
  logic             boot_active_q, boot_active_d;
  logic             boot_pend_q, boot_pend_d;
  logic             fetch_wait_q, fetch_wait_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [SYN_W-1:0] sync_cnt_q, sync_cnt_d;
  logic             spi_go_q, spi_go_d;
  logic [31:0]      spi_in_q, spi_in_d;
  logic [1:0]       spi_sel_q, spi_sel_d;
  logic             sw_ack_q, sw_ack_d;
  logic [31:0]      sw_rdata_q, sw_rdata_d;
  logic             sw_timeout_q, sw_timeout_d;
  logic             sync_q, sync_d;
  logic             boot_done_q, boot_done_d;
  logic [7:0]       err_q, err_d;
  logic             do_advance;

  // Next-state logic: arbitration, boot sequencing, timeout and sync pulse.
  always_comb begin
    state_d       = state_q;
    boot_addr_d   = boot_addr_q;
    word_d        = word_q;
    sel_d         = sel_q;
    src_sw_d      = src_sw_q;
    boot_active_d = boot_active_q;
    boot_pend_d   = boot_pend_q;
    fetch_wait_d  = fetch_wait_q;
    tmr_d         = tmr_q;
    sync_cnt_d    = sync_cnt_q;
    spi_go_d      = 1'b0;
    spi_in_d      = spi_in_q;
    spi_sel_d     = spi_sel_q;
    sw_ack_d      = 1'b0;
    sw_rdata_d    = sw_rdata_q;
    sw_timeout_d  = sw_timeout_q;
    sync_d        = sync_q;
    boot_done_d   = boot_done_q;
    err_d         = err_q;
    do_advance    = 1'b0;

    // A boot request arriving mid software transaction is remembered
    // and started once the software transaction has been acked.
    if (boot_start_i && !boot_active_q && state_q != ST_IDLE) begin
      boot_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (boot_start_i || boot_pend_q) begin
          boot_addr_d   = 8'd0;
          boot_active_d = 1'b1;
          boot_done_d   = 1'b0;
          boot_pend_d   = 1'b0;
          fetch_wait_d  = 1'b0;
          state_d       = ST_BOOT_FETCH;
        end else if (sw_req_i) begin
          word_d   = sw_data_i;
          sel_d    = sw_sel_i;
          src_sw_d = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_BOOT_FETCH: begin
        // First cycle lets the ROM register the new address; latch on the second.
        if (!fetch_wait_q) begin
          fetch_wait_d = 1'b1;
        end else begin
          word_d       = boot_word_i;
          sel_d        = boot_sel_i;
          src_sw_d     = 1'b0;
          fetch_wait_d = 1'b0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A level-style DONE from the previous word must drop before a new GO.
        if (!spi_done_i) begin
          spi_in_d  = word_q;
          spi_sel_d = sel_q;
          spi_go_d  = 1'b1;
          tmr_d     = '0;
          state_d   = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (spi_done_i || tmr_q == TMR_LAST) begin
          if (!spi_done_i && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
          if (src_sw_q) begin
            sw_rdata_d   = spi_done_i ? spi_out_i : 32'd0;
            sw_timeout_d = !spi_done_i;
            sw_ack_d     = 1'b1;
            state_d      = ST_SW_RESP;
          end else if (sw_req_i) begin
            // Fairness: a waiting software request goes before the next boot word.
            word_d   = sw_data_i;
            sel_d    = sw_sel_i;
            src_sw_d = 1'b1;
            state_d  = ST_ISSUE;
          end else begin
            do_advance = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_SW_RESP: begin
        if (boot_active_q) begin
          do_advance = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC_PULSE: begin
        if (sync_cnt_q == SYN_LAST) begin
          sync_d        = 1'b0;
          boot_done_d   = 1'b1;
          boot_active_d = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          sync_cnt_d = sync_cnt_q + SYN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Move to the next boot word, or finish the run with the sync pulse.
    if (do_advance) begin
      if (boot_addr_q == LAST_ADDR) begin
        sync_d     = 1'b1;
        sync_cnt_d = '0;
        state_d    = ST_SYNC_PULSE;
      end else begin
        boot_addr_d  = boot_addr_q + 8'd1;
        fetch_wait_d = 1'b0;
        state_d      = ST_BOOT_FETCH;
      end
    end
  end

  // State register with synchronous reset; GO is forced low in the reset cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      boot_addr_q   <= 8'd0;
      word_q        <= 32'd0;
      sel_q         <= 2'd0;
      src_sw_q      <= 1'b0;
      boot_active_q <= 1'b0;
      boot_pend_q   <= 1'b0;
      fetch_wait_q  <= 1'b0;
      tmr_q         <= '0;
      sync_cnt_q    <= '0;
      spi_go_q      <= 1'b0;
      spi_in_q      <= 32'd0;
      spi_sel_q     <= 2'd0;
      sw_ack_q      <= 1'b0;
      sw_rdata_q    <= 32'd0;
      sw_timeout_q  <= 1'b0;
      sync_q        <= 1'b0;
      boot_done_q   <= 1'b0;
      err_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      boot_addr_q   <= boot_addr_d;
      word_q        <= word_d;
      sel_q         <= sel_d;
      src_sw_q      <= src_sw_d;
      boot_active_q <= boot_active_d;
      boot_pend_q   <= boot_pend_d;
      fetch_wait_q  <= fetch_wait_d;
      tmr_q         <= tmr_d;
      sync_cnt_q    <= sync_cnt_d;
      spi_go_q      <= spi_go_d;
      spi_in_q      <= spi_in_d;
      spi_sel_q     <= spi_sel_d;
      sw_ack_q      <= sw_ack_d;
      sw_rdata_q    <= sw_rdata_d;
      sw_timeout_q  <= sw_timeout_d;
      sync_q        <= sync_d;
      boot_done_q   <= boot_done_d;
      err_q         <= err_d;
    end
  end

  assign boot_addr_o        = boot_addr_q;
  assign sw_ack_o           = sw_ack_q;
  assign sw_rdata_o         = sw_rdata_q;
  assign sw_timeout_o       = sw_timeout_q;
  assign spi_go_o           = spi_go_q;
  assign spi_in_o           = spi_in_q;
  assign spi_slave_select_o = spi_sel_q;
  assign sync_o             = sync_q;
  assign busy_o             = (state_q != ST_IDLE);
  assign boot_done_o        = boot_done_q;
  assign err_count_o        = err_q;

endmodule

// File: tb/tb_spi_clk_cfg_sequencer.sv
// Self-checking bench for spi_clk_cfg_sequencer: a randomized SPI engine
// model, a registered boot ROM, an expected-transaction queue and one
// per-cycle compare process.
module tb_spi_clk_cfg_sequencer;
  localparam int NB  = 4;
  localparam int TO  = 64;
  localparam int SPC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_start;
  logic [7:0]  boot_addr;
  logic [31:0] boot_word;
  logic [1:0]  boot_sel;
  logic        sw_req;
  logic [1:0]  sw_sel;
  logic [31:0] sw_data;
  logic        sw_ack;
  logic [31:0] sw_rdata;
  logic        sw_timeout;
  logic        spi_go;
  logic [31:0] spi_in;
  logic [1:0]  spi_sel;
  logic [31:0] spi_out;
  logic        spi_done;
  logic        sync;
  logic        busy;
  logic        boot_done;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  spi_clk_cfg_sequencer #(
    .N_BOOT_WORDS(NB), .TIMEOUT_CYCLES(TO), .SYNC_PULSE_CYCLES(SPC)
  ) dut (
    .clock_i(clk), .reset_i(rst), .boot_start_i(boot_start),
    .boot_addr_o(boot_addr), .boot_word_i(boot_word), .boot_sel_i(boot_sel),
    .sw_req_i(sw_req), .sw_sel_i(sw_sel), .sw_data_i(sw_data),
    .sw_ack_o(sw_ack), .sw_rdata_o(sw_rdata), .sw_timeout_o(sw_timeout),
    .spi_go_o(spi_go), .spi_in_o(spi_in), .spi_slave_select_o(spi_sel),
    .spi_out_i(spi_out), .spi_done_i(spi_done), .sync_o(sync),
    .busy_o(busy), .boot_done_o(boot_done), .err_count_o(err_count)
  );

  // Boot ROM: registered read, data follows the address one cycle later.
  logic [31:0] rom_word [NB];
  logic [1:0]  rom_sel  [NB];
  always @(posedge clk) begin
    boot_word <= rom_word[boot_addr[1:0]];
    boot_sel  <= rom_sel[boot_addr[1:0]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bounded wait expired or unexpected event", name);
  endtask

  // Expected SPI transactions, in the order GO pulses must appear.
  typedef struct {
    logic [31:0] word;
    logic [1:0]  sel;
    bit          is_sw;
    int          idx;
  } exp_t;
  exp_t exq[$];

  // SPI engine model: answers each GO after a random delay, holding DONE
  // as a pulse or a multi-cycle level, or stays silent when eng_resp=0.
  bit          eng_resp = 1'b1;
  int          dmin = 1, dmax = 30, hmax = 6;
  logic [31:0] eng_out_val = 32'd0;
  bit          cur_resp;
  int          cur_lat;
  logic [31:0] cur_out;
  int          eng_cnt, eng_d, eng_hold;
  bit          eng_pend = 1'b0;

  initial begin
    spi_done = 1'b0;
    spi_out  = 32'd0;
    forever begin
      @(negedge clk);
      if (spi_go) begin
        eng_d    = $urandom_range(dmax, dmin);
        eng_cnt  = 0;
        eng_pend = eng_resp;
        cur_resp = eng_resp;
        cur_lat  = eng_d + 1;
        cur_out  = eng_out_val;
        eng_hold = $urandom_range(hmax, 1);
      end else if (eng_pend) begin
        eng_cnt++;
        if (eng_cnt == eng_d) begin
          spi_done = 1'b1;
          spi_out  = cur_out;
          eng_pend = 1'b0;
        end
      end else if (spi_done) begin
        if (eng_hold <= 1) spi_done = 1'b0;
        else eng_hold--;
      end
    end
  end

  // Compare process: one sample per cycle, 1 time unit after the clock edge.
  int          cyc = 0, go_cyc = 0, sync_len = 0, model_err = 0;
  bit          outst = 1'b0, cur_sw = 1'b0, prev_go = 1'b0, prev_ack = 1'b0, prev_sync = 1'b0;
  logic [31:0] last_in = 32'd0, last_rdata = 32'd0;
  logic [1:0]  last_sel = 2'd0;

  initial begin
    exp_t e;
    bit   ok;
    int   lat;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ok  = cur_resp && (cur_lat <= TO);
      lat = ok ? cur_lat : TO;
      if (rst) begin
        outst = 1'b0; prev_go = 1'b0; prev_ack = 1'b0; prev_sync = 1'b0;
        sync_len = 0; last_in = 32'd0; last_sel = 2'd0; last_rdata = 32'd0;
        model_err = 0;
      end else begin
        if (outst && (cyc - go_cyc) == lat) begin
          outst = 1'b0;
          if (!ok && model_err < 255) model_err++;
        end
        chk("err_count", 32'(err_count), 32'(model_err));
        if (spi_go) begin
          chk("go_single_cycle", 32'(prev_go), 32'd0);
          chk("go_with_done_low", 32'(spi_done), 32'd0);
          chk("go_after_previous_done", 32'(outst), 32'd0);
          if (exq.size() == 0) begin
            fail_now("go_unexpected");
          end else begin
            e = exq.pop_front();
            chk("spi_in", spi_in, e.word);
            chk("spi_sel", 32'(spi_sel), 32'(e.sel));
            if (!e.is_sw) chk("boot_addr_order", 32'(boot_addr), 32'(e.idx));
            cur_sw = e.is_sw;
            $display("txn cyc=%0d %s idx=%0d word=0x%08h sel=%0d", cyc,
                     e.is_sw ? "sw  " : "boot", e.idx, spi_in, spi_sel);
          end
          outst    = 1'b1;
          go_cyc   = cyc;
          last_in  = spi_in;
          last_sel = spi_sel;
        end else begin
          chk("spi_in_stable", spi_in, last_in);
          chk("spi_sel_stable", 32'(spi_sel), 32'(last_sel));
        end
        if (sw_ack) begin
          chk("ack_single_cycle", 32'(prev_ack), 32'd0);
          chk("ack_for_sw_txn", 32'(cur_sw), 32'd1);
          chk("ack_latency", 32'(cyc - go_cyc), 32'(lat));
          chk("sw_timeout", 32'(sw_timeout), ok ? 32'd0 : 32'd1);
          chk("sw_rdata", sw_rdata, ok ? cur_out : 32'd0);
          $display("ack cyc=%0d rdata=0x%08h timeout=%0d", cyc, sw_rdata, sw_timeout);
          last_rdata = sw_rdata;
        end else begin
          chk("sw_rdata_stable", sw_rdata, last_rdata);
        end
        if (sync) begin
          sync_len++;
        end else if (prev_sync) begin
          chk("sync_length", 32'(sync_len), 32'(SPC));
          chk("boot_done_after_sync", 32'(boot_done), 32'd1);
          sync_len = 0;
        end
        prev_go   = spi_go;
        prev_ack  = sw_ack;
        prev_sync = sync;
      end
    end
  end

  task automatic push_boot(input int from);
    for (int i = from; i < NB; i++) exq.push_back('{rom_word[i], rom_sel[i], 1'b0, i});
  endtask

  task automatic push_sw(input logic [1:0] sel, input logic [31:0] data);
    exq.push_back('{data, sel, 1'b1, -1});
  endtask

  task automatic wait_ack(input int budget);
    int k = 0;
    while (!sw_ack && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!sw_ack) fail_now("wait_ack_timeout");
    sw_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(exq.size() == 0 && !busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) fail_now("wait_idle_timeout");
  endtask

  task automatic sw_txn(input logic [1:0] sel, input logic [31:0] data, input logic [31:0] out);
    eng_out_val = out;
    push_sw(sel, data);
    @(negedge clk);
    sw_req  = 1'b1;
    sw_sel  = sel;
    sw_data = data;
    wait_ack(400);
  endtask

  task automatic boot_with_sw(input logic [1:0] sel, input logic [31:0] data);
    eng_out_val = $urandom;
    exq.push_back('{rom_word[0], rom_sel[0], 1'b0, 0});
    push_sw(sel, data);
    push_boot(1);
    @(negedge clk);
    boot_start = 1'b1;
    sw_req     = 1'b1;
    sw_sel     = sel;
    sw_data    = data;
    @(negedge clk);
    boot_start = 1'b0;
    wait_ack(1000);
    wait_idle(2000);
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Stimulus: directed scenarios with randomized data, delays and DONE shapes.
  initial begin
    rst = 1'b1; boot_start = 1'b0; sw_req = 1'b0; sw_sel = 2'd0; sw_data = 32'd0;
    rom_word[0] = 32'h00000010; rom_sel[0] = 2'd0;
    rom_word[1] = 32'h00000021; rom_sel[1] = 2'd1;
    rom_word[2] = 32'h00000032; rom_sel[2] = 2'd2;
    rom_word[3] = 32'h00000043; rom_sel[3] = 2'd3;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_go", 32'(spi_go), 32'd0);
    chk("reset_boot_addr", 32'(boot_addr), 32'd0);
    chk("reset_spi_in", spi_in, 32'd0);
    chk("reset_sync", 32'(sync), 32'd0);
    chk("reset_boot_done", 32'(boot_done), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain boot run with DONE 20 cycles after GO.
    dmin = 19; dmax = 19;
    push_boot(0);
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
    wait_idle(2000);
    chk("boot_done_set", 32'(boot_done), 32'd1);
    chk("boot_err_zero", 32'(err_count), 32'd0);

    // Single software write.
    dmin = 1; dmax = 30;
    sw_txn(2'd1, 32'hDEADBEEF, 32'h12345678);
    chk("sw_rdata_literal", sw_rdata, 32'h12345678);
    chk("sw_timeout_literal", 32'(sw_timeout), 32'd0);
    wait_idle(100);

    // SW_REQ held across a boot run: boot0, SW, boot1..boot3.
    boot_with_sw(2'd2, 32'hCAFE0001);
    chk("interleave_boot_done", 32'(boot_done), 32'd1);

    // BOOT_START during a software transaction: boot follows the ack.
    eng_out_val = $urandom;
    push_sw(2'd3, 32'hA5A5A5A5);
    push_boot(0);
    @(negedge clk);
    sw_req = 1'b1; sw_sel = 2'd3; sw_data = 32'hA5A5A5A5;
    @(negedge clk);
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
    wait_ack(400);
    wait_idle(2000);

    // Random software traffic and randomized boot tables with interleaving.
    for (int i = 0; i < 10; i++) begin
      sw_txn(2'($urandom_range(3, 0)), $urandom, $urandom);
      wait_idle(100);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NB; i++) begin
        rom_word[i] = $urandom;
        rom_sel[i]  = 2'($urandom_range(3, 0));
      end
      repeat (2) @(negedge clk);
      boot_with_sw(2'($urandom_range(3, 0)), $urandom);
    end

    // Engine never answers: abort after the timeout window.
    eng_resp = 1'b0;
    sw_txn(2'd0, 32'h0BADF00D, 32'h11111111);
    chk("timeout_flag_literal", 32'(sw_timeout), 32'd1);
    chk("timeout_rdata_literal", sw_rdata, 32'd0);
    wait_idle(100);
    chk("timeout_err_one", 32'(err_count), 32'd1);
    for (int i = 0; i < 300; i++) begin
      sw_txn(2'($urandom_range(3, 0)), $urandom, 32'd0);
      wait_idle(100);
    end
    chk("err_count_saturated", 32'(err_count), 32'd255);

    // Reset while waiting on boot word 1, then a clean re-run.
    eng_resp = 1'b1;
    dmin = 20; dmax = 30;
    rom_word[0] = 32'h00000010; rom_sel[0] = 2'd0;
    rom_word[1] = 32'h00000021; rom_sel[1] = 2'd1;
    push_boot(0);
    @(negedge clk);
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
    begin
      int k = 0;
      while (!(spi_go && boot_addr == 8'd1) && k < 500) begin
        @(negedge clk);
        k++;
      end
      if (k >= 500) fail_now("wait_boot_word1");
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrun_reset_busy", 32'(busy), 32'd0);
    chk("midrun_reset_go", 32'(spi_go), 32'd0);
    chk("midrun_reset_boot_addr", 32'(boot_addr), 32'd0);
    chk("midrun_reset_boot_done", 32'(boot_done), 32'd0);
    chk("midrun_reset_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exq.delete();
    repeat (100) @(negedge clk);
    dmin = 1; dmax = 30;
    push_boot(0);
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
    wait_idle(2000);
    chk("rerun_boot_done", 32'(boot_done), 32'd1);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
